cache_ctrl: RTL
===============

# cache_ctrl

Two-way set-associative, write-back, write-allocate cache controller with one-word lines. It sits between the CPU data port and the latency memory model. CPU hits complete in the request cycle. Misses stall the CPU while the controller drives the memory's mem_read/mem_write handshake and waits for its read_allocate/write_back completion pulses. The block also keeps hit and miss counters for lab measurements.

## Interface
- INDEX_BITS, 6, set index width; 2^INDEX_BITS sets × 2 ways.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_read  in  1  load request; held stable while cpu_stall=1.
- cpu_write  in  1  store request; takes priority when cpu_read is also high.
- cpu_address  in  32  byte address; bits [1:0] ignored.
- cpu_data_in  in  32  store data.
- cpu_data_out  out  32  load data; valid when cpu_read=1 and cpu_stall=0.
- cpu_stall  out  1  combinational; high while a request is not yet complete.
- mem_read  out  1  level request to memory; held until completion.
- mem_write  out  1  level request to memory; never high together with mem_read.
- mem_address  out  32  word address = byte address >> 2.
- mem_wdata  out  32  writeback data, connected to memory mem_data_in.
- mem_rdata  in  32  memory mem_data_out.
- write_back  in  1  one-cycle pulse: memory write done.
- read_allocate  in  1  one-cycle pulse: mem_rdata valid.
- hit_count  out  32  completed-request hits.
- miss_count  out  32  misses.

## Operation
- Address split: index = addr[2+INDEX_BITS-1:2], tag = addr[31:2+INDEX_BITS].
- Per way: valid, dirty, tag, data. Per set: one lru bit, which names the victim way.
- All arrays are registers, so lookup is combinational.
- Hit: read returns way data combinationally. Write updates data and sets dirty at the clock edge. lru is set to the other way.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, request with hit: complete the request, hit_count+1, stay in IDLE.
- IDLE, request with miss: miss_count+1. Victim = way[lru]. If the victim is valid and dirty, go to WRITEBACK, otherwise go to ALLOCATE.
- WRITEBACK: mem_write=1, mem_address={victim tag, index}, mem_wdata = victim data. On write_back, go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_address = cpu word address. On read_allocate, load the victim with mem_rdata, the request tag, valid=1, dirty=0, then go to IDLE.
- Back in IDLE the request replays as a hit. That replay increments hit_count as well, so one missing request counts once in miss_count and once in hit_count.
- write_back is honoured only in WRITEBACK, and read_allocate only in ALLOCATE, and neither in the first cycle of the state. The memory's counters can emit stale pulses after a request drops, and these must be ignored.
- hit_count and miss_count wrap modulo 2^32.
- No request (both cpu_read and cpu_write low): no state change, cpu_stall=0.

## Timing
- Reset values: state=IDLE; all valid, dirty and lru = 0; mem_read=mem_write=0; mem_address, mem_wdata = 0; counters = 0; cpu_stall=0 while rst=1.
- Reset mid-miss: the FSM returns to IDLE and the mem signals drop the next cycle. Any later stray pulses are ignored.
- mem_* outputs are registered-state decodes. They are asserted from the first cycle in WRITEBACK/ALLOCATE and deasserted the cycle after the completion pulse is taken.
- The memory pulses in the 3rd cycle of a state, so a state lasts 3 cycles.
- Clean miss: stall for 4 cycles, complete in the 5th cycle after the request.
- Dirty miss: stall for 7 cycles, complete in the 8th.
- Hit: 0 stall cycles.
- The CPU must hold its request and data until cpu_stall=0. The request is consumed at the edge ending the cycle in which cpu_stall=0.

## Test plan
- Reset, then read 0x0000_0100 → stall 4 cycles; mem_read with mem_address=0x40; fill; data = memory word; miss_count=1, hit_count=1 (replay hit).
- Read 0x100 again immediately → cpu_stall=0 in the same cycle, correct data; hit_count=2, no memory activity.
- Write 0xDEADBEEF to 0x100, then reads to two other tags in the same set → the second miss evicts the dirty line. mem_write asserted with mem_address=0x40 and mem_wdata=0xDEADBEEF; total stall 7 cycles; a later read of 0x100 returns 0xDEADBEEF.
- LRU check: fill both ways of set 0, hit way 0, then miss → way 1 is replaced; way 0 still hits.
- Stale pulse: back-to-back clean misses on different sets → each fill uses the correct mem_rdata, and no early completion occurs on stray pulses.
- Assert rst in the 2nd cycle of ALLOCATE → next cycle mem_read=0, state IDLE, all lines invalid, counters 0; a following read misses normally.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU data port and memory handshake bundle for the cache controller.
interface cache_ctrl_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic        cpu_stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        write_back;
  logic        read_allocate;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Controller side
  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_data_in,
    input  mem_rdata, write_back, read_allocate,
    output cpu_data_out, cpu_stall,
    output mem_read, mem_write, mem_address, mem_wdata,
    output hit_count, miss_count
  );

  // CPU + memory side
  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_data_in,
    output mem_rdata, write_back, read_allocate,
    input  cpu_data_out, cpu_stall,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl.sv
// Two-way set-associative, write-back, write-allocate cache controller with
// one-word lines. Hits complete combinationally; misses stall while the
// controller runs the memory writeback/allocate handshake, then replay.
module cache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.slave bus
);
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;
  logic   first_q;   // first cycle of a memory state: completion pulses ignored
  logic   victim_q;  // way chosen at miss time

  logic [SETS-1:0][1:0]  valid_q, dirty_q;
  logic [SETS-1:0]       lru_q;
  logic [1:0][TAG_W-1:0] tag_q  [SETS];
  logic [1:0][31:0]      data_q [SETS];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit0, hit1, hit, hit_way, req, complete, miss, wb_done, fill;
  logic                  unused_addr;

  assign idx         = bus.cpu_address[2 +: INDEX_BITS];
  assign tag         = bus.cpu_address[31 -: TAG_W];
  assign unused_addr = ^bus.cpu_address[1:0];

  assign hit0     = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit1     = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign req      = bus.cpu_read | bus.cpu_write;
  assign complete = (state_q == IDLE) && req && hit;
  assign miss     = (state_q == IDLE) && req && !hit;
  assign wb_done  = (state_q == WRITEBACK) && !first_q && bus.write_back;
  assign fill     = (state_q == ALLOCATE)  && !first_q && bus.read_allocate;

  // Outputs decoded from registered state; stall forced low during reset
  assign bus.cpu_data_out = data_q[idx][hit_way];
  assign bus.cpu_stall    = !rst && req && !complete;
  assign bus.mem_read     = (state_q == ALLOCATE);
  assign bus.mem_write    = (state_q == WRITEBACK);
  assign bus.mem_address  = (state_q == WRITEBACK) ? {2'b00, tag_q[idx][victim_q], idx} :
                            (state_q == ALLOCATE)  ? {2'b00, bus.cpu_address[31:2]} : 32'h0;
  assign bus.mem_wdata    = (state_q == WRITEBACK) ? data_q[idx][victim_q] : 32'h0;

  // Next-state: miss picks writeback only when the lru victim is dirty
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss)
                   state_d = (valid_q[idx][lru_q[idx]] && dirty_q[idx][lru_q[idx]])
                             ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (wb_done) state_d = ALLOCATE;
      ALLOCATE:  if (fill)    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register, first-cycle flag and victim capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      first_q  <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      if (miss) victim_q <= lru_q[idx];
    end
  end

  // Line status bits: hits touch lru/dirty, fills install a clean valid line
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (complete) begin
        lru_q[idx] <= ~hit_way;
        if (bus.cpu_write) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag/data storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (complete && bus.cpu_write) data_q[idx][hit_way] <= bus.cpu_data_in;
    if (fill) begin
      data_q[idx][victim_q] <= bus.mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

  // Hit/miss counters; the replay after a miss counts as a hit too
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      if (complete) bus.hit_count  <= bus.hit_count + 32'd1;
      if (miss)     bus.miss_count <= bus.miss_count + 32'd1;
    end
  end
endmodule
